vector_regfile_stream: RTL and testbench

- Parametrised vector register file for the vector datapath: NUM_VECTORES registers of VECTOR_SIZE lanes × WIDTH bits.
- Two combinational vector read ports. Register 0 is hard-wired to zero.
- Three write paths:
  - full-vector write
  - scalar broadcast write
  - element-serial streaming fill with a valid/ready handshake, buffered in a staging vector and committed atomically.
- Sits between decode and the vector ALU. The stream port is fed by the memory/load unit one element per cycle.

---
 rtl/vector_regfile_stream.sv | 98 +++++++++
 tb/tb_vector_regfile_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vector_regfile_stream.sv
// vector_regfile_stream: vector register file with direct, broadcast and streamed-fill writes.
// Optional lane write mask on direct writes when VRF_LANE_MASK_EN is defined.
module vector_regfile_stream #(
    parameter int WIDTH        = 32,
    parameter int VECTOR_SIZE  = 16,
    parameter int NUM_VECTORES = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(NUM_VECTORES)-1:0]       v1,
    input  logic [$clog2(NUM_VECTORES)-1:0]       v2,
    output logic [VECTOR_SIZE-1:0][WIDTH-1:0]     vd1,
    output logic [VECTOR_SIZE-1:0][WIDTH-1:0]     vd2,
    input  logic                                  we_vec,
    input  logic                                  we_bcast,
    input  logic [$clog2(NUM_VECTORES)-1:0]       wv,
    input  logic [VECTOR_SIZE-1:0][WIDTH-1:0]     wd_vec,
    input  logic [WIDTH-1:0]                      wd_scalar,
    input  logic                                  fill_start,
    input  logic [$clog2(NUM_VECTORES)-1:0]       fill_dest,
    input  logic                                  fill_valid,
    input  logic [WIDTH-1:0]                      fill_data,
    output logic                                  fill_ready,
    input  logic                                  fill_abort,
    output logic                                  fill_done,
`ifdef VRF_LANE_MASK_EN
    input  logic [VECTOR_SIZE-1:0]                wmask,
`endif
    output logic                                  busy
);
    localparam int AW = $clog2(NUM_VECTORES);
    localparam int CW = $clog2(VECTOR_SIZE);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [VECTOR_SIZE-1:0][WIDTH-1:0] r_vec [NUM_VECTORES];
    logic [VECTOR_SIZE-1:0][WIDTH-1:0] r_stage;
    logic [1:0]                        r_state;
    logic [CW-1:0]                     r_cnt;
    logic [AW-1:0]                     r_dest;
    logic [VECTOR_SIZE-1:0][WIDTH-1:0] w_dir_data;
    logic [VECTOR_SIZE-1:0]            w_mask;

`ifdef VRF_LANE_MASK_EN
    assign w_mask = wmask;
`else
    assign w_mask = '1;
`endif

    always_comb begin
        w_dir_data = '0;
        for (int i = 0; i < VECTOR_SIZE; i++)
            w_dir_data[i] = we_vec ? wd_vec[i] : wd_scalar;
    end

    assign vd1        = (v1 == '0) ? '0 : r_vec[v1];
    assign vd2        = (v2 == '0) ? '0 : r_vec[v2];
    assign fill_ready = r_state == S_FILL;
    assign fill_done  = r_state == S_COMMIT;
    assign busy       = r_state != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_VECTORES; j++)
                r_vec[j] <= '0;
            r_stage <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dest  <= '0;
        end else begin
            if ((we_vec || we_bcast) && wv != '0)
                for (int i = 0; i < VECTOR_SIZE; i++)
                    if (w_mask[i])
                        r_vec[wv][i] <= w_dir_data[i];
            // Issued after the direct write so a same-register commit overrides it
            if (r_state == S_COMMIT && r_dest != '0)
                r_vec[r_dest] <= r_stage;
            if (r_state == S_IDLE) begin
                if (fill_start) begin
                    r_dest  <= fill_dest;
                    r_cnt   <= '0;
                    r_state <= S_FILL;
                end
            end else if (r_state == S_FILL) begin
                if (fill_abort)
                    r_state <= S_IDLE;
                else if (fill_valid) begin
                    r_stage[r_cnt] <= fill_data;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == CW'(VECTOR_SIZE - 1))
                        r_state <= S_COMMIT;
                end
            end else
                r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_vector_regfile_stream.sv
// tb_vector_regfile_stream: directed stimulus checked each cycle against a queue-based model.
module tb_vector_regfile_stream;
    localparam int W  = 32;
    localparam int VS = 16;
    localparam int NV = 8;
    localparam int AW = $clog2(NV);
    typedef logic [VS-1:0][W-1:0] vec_t;

    logic clk = 0, rst = 1;
    logic [AW-1:0] v1 = 0, v2 = 0, wv = 0, fill_dest = 0;
    vec_t vd1, vd2, wd_vec = '0;
    logic we_vec = 0, we_bcast = 0, fill_start = 0, fill_valid = 0, fill_abort = 0;
    logic [W-1:0] wd_scalar = 0, fill_data = 0;
    logic fill_ready, fill_done, busy;
    logic [VS-1:0] wmask = '1;

    int n_vec = 0, n_bad = 0;
    bit started = 0;

    vector_regfile_stream #(.WIDTH(W), .VECTOR_SIZE(VS), .NUM_VECTORES(NV)) dut (
        .clk(clk), .rst(rst), .v1(v1), .v2(v2), .vd1(vd1), .vd2(vd2),
        .we_vec(we_vec), .we_bcast(we_bcast), .wv(wv), .wd_vec(wd_vec), .wd_scalar(wd_scalar),
        .fill_start(fill_start), .fill_dest(fill_dest), .fill_valid(fill_valid),
        .fill_data(fill_data), .fill_ready(fill_ready), .fill_abort(fill_abort),
        .fill_done(fill_done),
`ifdef VRF_LANE_MASK_EN
        .wmask(wmask),
`endif
        .busy(busy));

    always #5 clk = ~clk;

    // Model: register contents, a fill-in-progress flag with its accepted elements, commit flag
    vec_t m [NV];
    logic [W-1:0] q [$];
    bit m_fill = 0, m_commit = 0;
    logic [AW-1:0] m_dest = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NV; j++) m[j] = '0;
            m_fill = 0; m_commit = 0; q.delete();
        end else begin
            if ((we_vec || we_bcast) && wv != 0)
                for (int i = 0; i < VS; i++)
                    if (wmask[i]) m[wv][i] = we_vec ? wd_vec[i] : wd_scalar;
            if (m_commit) begin
                if (m_dest != 0)
                    for (int i = 0; i < VS; i++) m[m_dest][i] = q[i];
                m_commit = 0;
            end else if (m_fill) begin
                if (fill_abort) begin m_fill = 0; q.delete(); end
                else if (fill_valid) begin
                    q.push_back(fill_data);
                    if (q.size() == VS) begin m_fill = 0; m_commit = 1; end
                end
            end else if (fill_start) begin
                m_fill = 1; m_dest = fill_dest; q.delete();
            end
        end
    end

    function automatic vec_t mread(input logic [AW-1:0] v);
        return (v == 0) ? vec_t'(0) : m[v];
    endfunction

    task automatic chk(input string name, input logic [VS*W-1:0] act, input logic [VS*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("vd1", vd1, mread(v1));
        chk("vd2", vd2, mread(v2));
        chk("fill_ready", fill_ready, m_fill);
        chk("fill_done", fill_done, m_commit);
        chk("busy", busy, m_fill | m_commit);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    function automatic vec_t ramp(input logic [W-1:0] base);
        vec_t r;
        for (int i = 0; i < VS; i++) r[i] = base + W'(i);
        return r;
    endfunction

    function automatic vec_t splat(input logic [W-1:0] x);
        vec_t r;
        for (int i = 0; i < VS; i++) r[i] = x;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            fill_valid = 1; fill_data = base + W'(k); cyc();
        end
        fill_valid = 0;
    endtask

    task automatic start(input logic [AW-1:0] d);
        fill_start = 1; fill_dest = d; cyc(); fill_start = 0;
    endtask

    initial begin
        cyc(); cyc();
        rst = 0; started = 1;
        v1 = 3; v2 = 0; #1;
        chk("reset_vd1", vd1, '0);
        chk("reset_vd2", vd2, '0);
        chk("reset_flags", {busy, fill_ready, fill_done}, 3'b000);

        we_vec = 1; wv = 2; wd_vec = ramp(100); cyc();
        wv = 0; wd_vec = splat(32'h1234); v1 = 2; #1;
        chk("vec_write_r2", vd1, ramp(100));
        cyc(); we_vec = 0; v1 = 0; #1;
        chk("vec_write_r0", vd1, '0);

        we_vec = 1; we_bcast = 1; wv = 5; wd_vec = splat(7); wd_scalar = 32'hDEADBEEF; cyc();
        we_vec = 0; we_bcast = 0; v1 = 5; #1;
        chk("vec_priority", vd1, splat(7));

        v1 = 4;
        start(4);
        chk("fill_busy", {busy, fill_ready}, 2'b11);
        send(32'h10, 6);
        cyc(); cyc();
        send(32'h16, 10);
        chk("commit_pulse", fill_done, 1'b1);
        chk("pre_commit_r4", vd1, '0);
        cyc();
        chk("post_commit_r4", vd1, ramp(32'h10));
        chk("post_commit_idle", {busy, fill_done}, 2'b00);

        v1 = 6;
        start(6);
        send(32'h60, 8);
        fill_abort = 1; fill_valid = 1; fill_data = 32'hBAD; cyc();
        fill_abort = 0; fill_valid = 0;
        chk("abort_idle", busy, 1'b0);
        chk("abort_r6", vd1, '0);
        start(3);
        chk("restart_accept", fill_ready, 1'b1);
        send(32'h300, 8);
        we_bcast = 1; wv = 5; wd_scalar = 32'h5A5A; cyc(); we_bcast = 0;
        send(32'h308, 8);
        we_vec = 1; wv = 3; wd_vec = splat(32'h99); fill_abort = 1; cyc();
        we_vec = 0; fill_abort = 0; v1 = 3; v2 = 5; #1;
        chk("commit_wins", vd1, ramp(32'h300));
        chk("bcast_during_fill", vd2, splat(32'h5A5A));

        start(3);
        send(32'h400, 16);
        we_vec = 1; wv = 1; wd_vec = splat(32'h77); cyc();
        we_vec = 0; v2 = 1; #1;
        chk("commit_r3", vd1, ramp(32'h400));
        chk("direct_r1", vd2, splat(32'h77));

        start(0);
        send(32'h500, 16);
        chk("dest0_pulse", fill_done, 1'b1);
        cyc();

`ifdef VRF_LANE_MASK_EN
        we_bcast = 1; wv = 7; wd_scalar = 32'h55; cyc();
        wmask = 16'h00FF; wd_scalar = 32'hAA; cyc();
        we_bcast = 0; wmask = '1; v1 = 7; #1;
        begin
            vec_t e;
            for (int i = 0; i < VS; i++) e[i] = (i < 8) ? 32'hAA : 32'h55;
            chk("lane_mask", vd1, e);
        end
`endif

        start(7);
        send(32'h700, 3);
        rst = 1; cyc(); rst = 0; v1 = 4; v2 = 7; #1;
        chk("reset_midfill", {vd1, vd2}, '0);
        chk("reset_midfill_idle", busy, 1'b0);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
